seg_scan_driver: RTL

//  Downstream stage for the hex counter/decoder path. Time-multiplexes DIGITS
//  hex nibbles onto the shared 7-seg bus, driving io_sel and io_seg, both

---
 rtl/seg_pkg.sv | 37 +++
 rtl/seg_hex_decoder.sv | 34 +++
 rtl/seg_scan_driver.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan path.
//   SEG_OFF     : active-low segment bus value with every segment dark
//   state_t     : scan FSM states (BLANK gap, DRIVE of one digit)
//   GLYPH_0..F  : active-high g..a patterns for each hex nibble
//   clog2_min1  : clog2 clamped to at least 1 bit for counter widths
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // A counter for N states needs clog2(N) bits, but never fewer than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to 7-segment glyph decoder.
//   i_nibble  : 4-bit hex value
//   o_glyph_c : active-high segments, bit 6..0 = g..a
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_glyph_c
);

  always_comb begin
    o_glyph_c = '0;
    case (i_nibble)
      4'h0: o_glyph_c = GLYPH_0;
      4'h1: o_glyph_c = GLYPH_1;
      4'h2: o_glyph_c = GLYPH_2;
      4'h3: o_glyph_c = GLYPH_3;
      4'h4: o_glyph_c = GLYPH_4;
      4'h5: o_glyph_c = GLYPH_5;
      4'h6: o_glyph_c = GLYPH_6;
      4'h7: o_glyph_c = GLYPH_7;
      4'h8: o_glyph_c = GLYPH_8;
      4'h9: o_glyph_c = GLYPH_9;
      4'hA: o_glyph_c = GLYPH_A;
      4'hB: o_glyph_c = GLYPH_B;
      4'hC: o_glyph_c = GLYPH_C;
      4'hD: o_glyph_c = GLYPH_D;
      4'hE: o_glyph_c = GLYPH_E;
      4'hF: o_glyph_c = GLYPH_F;
      default: o_glyph_c = '0;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with tear-free double buffering.
// Each digit slot is a BLANK gap (all digits off) followed by a DRIVE phase.
//   clk, rst   : clock, synchronous active-high reset
//   values     : hex nibbles, digit i = values[4i+3:4i]
//   dp         : decimal point per digit, 1 = lit
//   digit_en   : per-digit enable, sampled live during DRIVE
//   load       : capture values/dp into the pending buffer
//   io_sel     : active-low digit select, one-hot-low or all ones
//   io_seg     : active-low segments, [7] = dp, [6:0] = g..a
//   cur_digit  : digit slot currently in progress
//   frame_done : one-cycle pulse after the last digit's DRIVE ends
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_CYCLES  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*DIGITS-1:0]       values,
  input  logic [DIGITS-1:0]         dp,
  input  logic [DIGITS-1:0]         digit_en,
  input  logic                      load,
  output logic [DIGITS-1:0]         io_sel,
  output logic [7:0]                io_seg,
  output logic [$clog2(DIGITS)-1:0] cur_digit,
  output logic                      frame_done
);

  localparam int unsigned DW   = $clog2(DIGITS);
  localparam int unsigned VW   = 4 * DIGITS;
  localparam int unsigned TMAX = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
  localparam int unsigned TW   = clog2_min1(TMAX);

  // Scan sequencing state
  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [DW-1:0]   r_cur_digit;

  // Double buffer: pending collects loads, active feeds the display
  logic [VW-1:0]     r_pend_val;
  logic [DIGITS-1:0] r_pend_dp;
  logic              r_pend_valid;
  logic [VW-1:0]     r_act_val;
  logic [DIGITS-1:0] r_act_dp;

  // Pin registers
  logic [DIGITS-1:0] r_sel;
  logic [7:0]        r_seg;
  logic              r_frame_done;

  // Next-state / next-output signals
  state_t            w_state_nxt;
  logic [TW-1:0]     w_timer_nxt;
  logic [DW-1:0]     w_digit_nxt;
  logic              w_frame_end;
  logic [DIGITS-1:0] w_sel_nxt;
  logic [7:0]        w_seg_nxt;

  // Data of the digit in progress
  logic [3:0] w_nibble;
  logic       w_dp;
  logic       w_en;
  logic [6:0] w_glyph;

  // Select the active nibble, dp and live enable of the current digit
  always_comb begin
    w_nibble = '0;
    w_dp     = 1'b0;
    w_en     = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_cur_digit == DW'(i)) begin
        w_nibble = r_act_val[4*i +: 4];
        w_dp     = r_act_dp[i];
        w_en     = digit_en[i];
      end
    end
  end

  seg_hex_decoder u_dec (
    .i_nibble  (w_nibble),
    .o_glyph_c (w_glyph)
  );

  // FSM state register with timer and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BLANK;
      r_timer     <= '0;
      r_cur_digit <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_cur_digit <= w_digit_nxt;
    end
  end

  // Next state, slot timing and the pin values for the next cycle
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + TW'(1);
    w_digit_nxt = r_cur_digit;
    w_frame_end = 1'b0;
    w_sel_nxt   = '1;
    w_seg_nxt   = SEG_OFF;
    case (r_state)
      BLANK: begin
        if (r_timer == TW'(BLANK_CYCLES - 1)) begin
          w_state_nxt = DRIVE;
          w_timer_nxt = '0;
        end
      end
      DRIVE: begin
        // A disabled digit keeps its slot timing but stays dark
        if (w_en) begin
          w_sel_nxt = ~(DIGITS'(1) << r_cur_digit);
          w_seg_nxt = ~{w_dp, w_glyph};
        end
        if (r_timer == TW'(SCAN_CYCLES - 1)) begin
          w_state_nxt = BLANK;
          w_timer_nxt = '0;
          if (r_cur_digit == DW'(DIGITS - 1)) begin
            w_digit_nxt = '0;
            w_frame_end = 1'b1;
          end else begin
            w_digit_nxt = r_cur_digit + DW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = BLANK;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Pending/active buffers; active only moves on the frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
    end else begin
      if (load) begin
        r_pend_val   <= values;
        r_pend_dp    <= dp;
        r_pend_valid <= 1'b1;
      end
      if (w_frame_end) begin
        // A load on the boundary itself bypasses pending straight to active
        if (load) begin
          r_act_val    <= values;
          r_act_dp     <= dp;
          r_pend_valid <= 1'b0;
        end else if (r_pend_valid) begin
          r_act_val    <= r_pend_val;
          r_act_dp     <= r_pend_dp;
          r_pend_valid <= 1'b0;
        end
      end
    end
  end

  // Output registers: pins lag the FSM by exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel        <= '1;
      r_seg        <= SEG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_sel        <= w_sel_nxt;
      r_seg        <= w_seg_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  assign io_sel     = r_sel;
  assign io_seg     = r_seg;
  assign cur_digit  = r_cur_digit;
  assign frame_done = r_frame_done;

endmodule
